// File: rtl/uart_tx_scheduler.sv
// UART transmitter that pulls bytes from a first-word-fall-through TX FIFO and
// serialises them as start / 8 data (LSB first) / optional parity / 1-2 stop bits.
module uart_tx_scheduler #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic [3:0]            Cntrl,
    input  logic [19:0]           BaudDiv,
    input  logic                  Empty,
    input  logic [DATA_WIDTH-1:0] RData,
    output logic                  RInc,
    output logic                  TXD,
    output logic                  Busy,
    output logic                  FrameDone
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t      state_q;
    logic [19:0] bitCnt_q;
    logic [19:0] bitCnt_d;
    logic [19:0] baud_q;
    logic [7:0]  shift_q;
    logic [2:0]  bitIdx_q;
    logic        parityEn_q;
    logic        parityBit_q;
    logic        twoStop_q;
    logic        stopSecond_q;
    logic        txd_q;
    logic        busy_q;
    logic        done_q;
    logic        bitTick;
    logic        unusedRData;

    // Only the low byte of the FIFO word goes on the line.
    assign unusedRData = ^RData[DATA_WIDTH-1:8];

    assign bitTick   = (bitCnt_q == baud_q);
    assign bitCnt_d  = bitCnt_q + 20'd1;
    assign RInc      = !reset && (state_q == IDLE) && Cntrl[0] && !Empty;
    assign TXD       = txd_q;
    assign Busy      = busy_q;
    assign FrameDone = done_q;

    always_ff @(posedge UCLK) begin
        if (reset) begin
            state_q      <= IDLE;
            bitCnt_q     <= '0;
            baud_q       <= '0;
            shift_q      <= '0;
            bitIdx_q     <= '0;
            parityEn_q   <= 1'b0;
            parityBit_q  <= 1'b0;
            twoStop_q    <= 1'b0;
            stopSecond_q <= 1'b0;
            txd_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                    // Frame settings are latched here and held until the frame ends.
                    if (RInc) begin
                        shift_q      <= RData[7:0];
                        baud_q       <= BaudDiv;
                        parityEn_q   <= Cntrl[1];
                        parityBit_q  <= (^RData[7:0]) ^ Cntrl[2];
                        twoStop_q    <= Cntrl[3];
                        stopSecond_q <= 1'b0;
                        bitIdx_q     <= '0;
                        bitCnt_q     <= '0;
                        txd_q        <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= START;
                    end
                end
                START: begin
                    if (bitTick) begin
                        bitCnt_q <= '0;
                        txd_q    <= shift_q[0];
                        state_q  <= DATA;
                    end else begin
                        bitCnt_q <= bitCnt_d;
                    end
                end
                DATA: begin
                    if (bitTick) begin
                        bitCnt_q <= '0;
                        if (bitIdx_q == 3'd7) begin
                            if (parityEn_q) begin
                                txd_q   <= parityBit_q;
                                state_q <= PARITY;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            shift_q  <= {1'b0, shift_q[7:1]};
                            txd_q    <= shift_q[1];
                            bitIdx_q <= bitIdx_q + 3'd1;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_d;
                    end
                end
                PARITY: begin
                    if (bitTick) begin
                        bitCnt_q <= '0;
                        txd_q    <= 1'b1;
                        state_q  <= STOP;
                    end else begin
                        bitCnt_q <= bitCnt_d;
                    end
                end
                STOP: begin
                    // A second stop bit restarts the bit counter without leaving STOP.
                    if (bitTick) begin
                        bitCnt_q <= '0;
                        if (twoStop_q && !stopSecond_q) begin
                            stopSecond_q <= 1'b1;
                        end else begin
                            txd_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_d;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler with a queue-based FIFO model
// and a per-cycle log of TXD/Busy/FrameDone/RInc.
module tb_uart_tx_scheduler;

    logic        UCLK;
    logic        reset;
    logic [3:0]  Cntrl;
    logic [19:0] BaudDiv;
    logic        Empty;
    logic [31:0] RData;
    logic        RInc;
    logic        TXD;
    logic        Busy;
    logic        FrameDone;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] fifo[$];
    logic        txdLog[$];
    logic        busyLog[$];
    int          rincIdx[$];
    int          doneIdx[$];
    int          cyc;
    int          rincCount;
    int          doneCount;
    int          busyCount;

    uart_tx_scheduler #(.DATA_WIDTH(32)) dut (
        .UCLK      (UCLK),
        .reset     (reset),
        .Cntrl     (Cntrl),
        .BaudDiv   (BaudDiv),
        .Empty     (Empty),
        .RData     (RData),
        .RInc      (RInc),
        .TXD       (TXD),
        .Busy      (Busy),
        .FrameDone (FrameDone)
    );

    initial UCLK = 1'b0;
    always #5 UCLK = ~UCLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearLogs();
        txdLog.delete();
        busyLog.delete();
        rincIdx.delete();
        doneIdx.delete();
        cyc       = 0;
        rincCount = 0;
        doneCount = 0;
        busyCount = 0;
    endtask

    task automatic pushWord(input logic [31:0] w);
        fifo.push_back(w);
        Empty = 1'b0;
        RData = fifo[0];
    endtask

    // One clock: sample RInc before the edge, pop the model FIFO and log outputs after it.
    task automatic applyStimulus();
        logic rincPre;
        #1;
        rincPre = RInc;
        @(posedge UCLK);
        #1;
        if (rincPre) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            rincCount++;
            rincIdx.push_back(cyc);
        end
        Empty = (fifo.size() == 0);
        RData = (fifo.size() == 0) ? 32'h0 : fifo[0];
        txdLog.push_back(TXD);
        busyLog.push_back(Busy);
        if (Busy) busyCount++;
        if (FrameDone) begin
            doneCount++;
            doneIdx.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic runFor(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    // Compares the logged line against seq (bit i of seq is the i-th bit period),
    // plus Busy during the frame and one idle-high cycle right after it.
    task automatic checkFrame(input string tag, input int start, input logic [15:0] seq,
                              input int nbits, input int period);
        int errs;
        int len;
        errs = 0;
        len  = nbits * period;
        if (start < 0 || start + len >= txdLog.size()) begin
            errs = 1000;
        end else begin
            for (int i = 0; i < len; i++) begin
                if (txdLog[start + i] !== seq[i / period]) errs++;
                if (busyLog[start + i] !== 1'b1) errs++;
            end
            if (txdLog[start + len] !== 1'b1) errs++;
            if (busyLog[start + len] !== 1'b0) errs++;
        end
        checkOutput(tag, errs, 0);
    endtask

    initial begin
        int s;
        reset   = 1'b1;
        Cntrl   = 4'b0000;
        BaudDiv = 20'd0;
        Empty   = 1'b1;
        RData   = 32'h0;
        clearLogs();
        runFor(3);
        checkOutput("reset_txd", {31'h0, TXD}, 32'h1);
        checkOutput("reset_busy", {31'h0, Busy}, 32'h0);
        checkOutput("reset_done", {31'h0, FrameDone}, 32'h0);
        checkOutput("reset_rinc", {31'h0, RInc}, 32'h0);
        reset = 1'b0;
        runFor(2);

        $display("[TB] 8N1 BaudDiv=3 word 0xA5");
        BaudDiv = 20'd3;
        Cntrl   = 4'b0001;
        pushWord(32'hDEAD_BEA5);
        clearLogs();
        runFor(50);
        s = (rincIdx.size() > 0) ? rincIdx[0] : -1;
        checkOutput("a5_rinc_count", rincCount, 1);
        checkFrame("a5_frame", s, 16'h034A, 10, 4);
        checkOutput("a5_busy_cycles", busyCount, 40);
        checkOutput("a5_done_count", doneCount, 1);
        checkOutput("a5_done_pos", (doneIdx.size() > 0) ? doneIdx[0] : -1, s + 40);

        $display("[TB] even parity BaudDiv=0");
        BaudDiv = 20'd0;
        Cntrl   = 4'b0011;
        pushWord(32'h0000_00A5);
        clearLogs();
        runFor(15);
        s = (rincIdx.size() > 0) ? rincIdx[0] : -1;
        checkFrame("even_par_frame", s, 16'h054A, 11, 1);
        checkOutput("even_par_busy", busyCount, 11);

        $display("[TB] odd parity BaudDiv=0");
        Cntrl = 4'b0111;
        pushWord(32'h0000_00A5);
        clearLogs();
        runFor(15);
        s = (rincIdx.size() > 0) ? rincIdx[0] : -1;
        checkFrame("odd_par_frame", s, 16'h074A, 11, 1);
        checkOutput("odd_par_busy", busyCount, 11);

        $display("[TB] two stop bits BaudDiv=1 word 0xFF");
        BaudDiv = 20'd1;
        Cntrl   = 4'b1001;
        pushWord(32'h0000_00FF);
        clearLogs();
        runFor(28);
        s = (rincIdx.size() > 0) ? rincIdx[0] : -1;
        checkFrame("two_stop_frame", s, 16'h07FE, 11, 2);
        checkOutput("two_stop_busy", busyCount, 22);
        checkOutput("two_stop_done", doneCount, 1);

        $display("[TB] back-to-back 0x01 0x02 0x03");
        BaudDiv = 20'd0;
        Cntrl   = 4'b0001;
        pushWord(32'h01);
        pushWord(32'h02);
        pushWord(32'h03);
        clearLogs();
        runFor(40);
        checkOutput("b2b_rinc_count", rincCount, 3);
        checkOutput("b2b_done_count", doneCount, 3);
        checkOutput("b2b_busy", busyCount, 30);
        if (rincIdx.size() == 3) begin
            checkOutput("b2b_gap1", rincIdx[1] - rincIdx[0], 11);
            checkOutput("b2b_gap2", rincIdx[2] - rincIdx[1], 11);
            checkFrame("b2b_frame0", rincIdx[0], 16'h0202, 10, 1);
            checkFrame("b2b_frame1", rincIdx[1], 16'h0204, 10, 1);
            checkFrame("b2b_frame2", rincIdx[2], 16'h0206, 10, 1);
        end else begin
            checkOutput("b2b_rinc_index_count", rincIdx.size(), 3);
        end

        $display("[TB] mid-frame TxEn clear and BaudDiv change");
        BaudDiv = 20'd3;
        Cntrl   = 4'b0001;
        pushWord(32'h5A);
        pushWord(32'h33);
        clearLogs();
        runFor(6);
        Cntrl   = 4'b0000;
        BaudDiv = 20'd7;
        runFor(60);
        s = (rincIdx.size() > 0) ? rincIdx[0] : -1;
        checkOutput("midframe_rinc_count", rincCount, 1);
        checkFrame("midframe_frame", s, 16'h02B4, 10, 4);
        checkOutput("midframe_busy", busyCount, 40);
        checkOutput("midframe_done", doneCount, 1);

        $display("[TB] reset during DATA");
        BaudDiv = 20'd1;
        Cntrl   = 4'b0001;
        clearLogs();
        runFor(6);
        pushWord(32'h44);
        reset = 1'b1;
        applyStimulus();
        checkOutput("abort_txd", {31'h0, TXD}, 32'h1);
        checkOutput("abort_busy", {31'h0, Busy}, 32'h0);
        runFor(2);
        checkOutput("abort_rinc_count", rincCount, 1);
        checkOutput("abort_done", doneCount, 0);
        reset = 1'b0;
        Cntrl = 4'b0000;
        runFor(3);
        checkOutput("abort_txen_off_rinc", rincCount, 1);
        checkOutput("abort_txen_off_busy", {31'h0, Busy}, 32'h0);
        Cntrl = 4'b0001;
        applyStimulus();
        checkOutput("abort_resume_rinc", rincCount, 2);
        checkOutput("abort_resume_txd", {31'h0, TXD}, 32'h0);
        runFor(30);
        checkOutput("abort_resume_done", doneCount, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, TX FIFO read-data width; only bits [7:0] are transmitted.
REQ-002 SHALL have port UCLK, input, 1, the only clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port Cntrl, input, 4: [0] TxEn, [1] ParityEn, [2] ParityOdd, [3] TwoStop.
REQ-005 SHALL have port BaudDiv, input, 20, bit period minus one, in UCLK cycles.
REQ-006 SHALL have port Empty, input, 1, TX FIFO empty flag.
REQ-007 SHALL have port RData, input, DATA_WIDTH, TX FIFO head word; valid whenever Empty=0 (first-word fall-through).
REQ-008 SHALL have port RInc, output, 1, TX FIFO pop strobe.
REQ-009 SHALL have port TXD, output, 1, serial line, idle high.
REQ-010 SHALL have port Busy, output, 1, high while a frame is in progress.
REQ-011 SHALL have port FrameDone, output, 1, one-cycle pulse at end of frame.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL in IDLE with TxEn=1 and Empty=0 drive RInc=1 combinationally for exactly that cycle, capture RData[7:0], Cntrl[3:1] and BaudDiv at that edge, and enter START.
REQ-014 SHALL never assert RInc outside IDLE or when Empty=1.
REQ-015 SHALL use the captured Cntrl/BaudDiv for the whole frame; mid-frame changes to the inputs, including TxEn going to 0, SHALL NOT affect the current frame.
REQ-016 SHALL run a 20-bit bit counter that clears on every state entry and raises a bit tick when it equals captured BaudDiv; each bit lasts BaudDiv+1 cycles (BaudDiv=0 gives 1 cycle per bit).
REQ-017 SHALL register TXD: IDLE=1, START=0, DATA=current data bit LSB first, PARITY=parity bit, STOP=1.
REQ-018 SHALL in DATA shift out 8 bits using a 3-bit index, leaving on the tick of bit 7 for PARITY if ParityEn, else for STOP.
REQ-019 SHALL compute parity as XOR of the 8 data bits, inverted when ParityOdd=1.
REQ-020 SHALL hold STOP for 1 bit period, or 2 when TwoStop=1, then return to IDLE.
REQ-021 SHALL pulse FrameDone for one cycle on the STOP-to-IDLE transition.
REQ-022 SHALL assert Busy in every state except IDLE.
REQ-023 SHALL on back-to-back frames spend exactly one IDLE cycle (TXD=1) between the last stop bit and the next start bit.
REQ-024 SHALL have a frame length of (BaudDiv+1) x (10 + ParityEn + TwoStop) cycles, from the first START cycle to the last STOP cycle.

Reset
REQ-025 SHALL on reset=1 go to IDLE and set TXD=1, RInc=0, Busy=0 and FrameDone=0, with all counters and the shift register at 0.
REQ-026 SHALL abort any frame when reset is asserted mid-frame; TXD=1 from the next edge, and there is no FrameDone pulse and no further RInc until reset is released.

Verification
REQ-027 BaudDiv=3, Cntrl=4'b0001, one word 0xA5 -> one RInc pulse; TXD = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); FrameDone once; Busy high 40 cycles.
REQ-028 BaudDiv=0, Cntrl=4'b0011, 0xA5 -> parity bit 0, frame 11 cycles; with Cntrl=4'b0111 -> parity bit 1.
REQ-029 BaudDiv=1, Cntrl=4'b1001, 0xFF -> stop high 4 cycles, frame 22 cycles.
REQ-030 Three words 0x01, 0x02, 0x03 queued, BaudDiv=0, 8N1 -> three RInc pulses 11 cycles apart; one-cycle TXD-high gap between frames.
REQ-031 TxEn cleared and BaudDiv changed mid-frame -> current frame completes at the original timing; no further RInc while TxEn=0 and Empty=0.
REQ-032 Reset asserted during DATA -> TXD=1, Busy=0 next cycle; FIFO word not re-popped until IDLE with TxEn=1 after release.
